// File: rtl/keypad_pkg.sv
// Shared key map, state/tone encodings and the keypad event decoder for the code lock.
// Pure declarations; no timing of its own.
package keypad_pkg;

    localparam int KEY_ENTER     = 0;
    localparam int KEY_CLEAR     = 12;
    localparam int KEY_CLEAR_ALL = 8;
    localparam int KEY_SET       = 4;
    localparam int DIGIT_BIT [10] = '{3, 7, 6, 5, 11, 10, 9, 15, 14, 13};

    localparam logic [3:0] BLANK      = 4'hF;
    localparam logic [3:0] PASS_GLYPH = 4'hA;

    typedef enum logic [1:0] {ENTRY, PASS, NEWCODE, LOCKOUT} state_t;
    typedef enum logic [1:0] {TONE_NONE, TONE_CLICK, TONE_OK, TONE_FAIL} tone_t;
    typedef enum logic [2:0] {K_NONE, K_DIGIT, K_ENTER, K_CLEAR, K_CLEAR_ALL, K_SET} key_kind_t;

    typedef struct packed {
        key_kind_t  kind;
        logic [3:0] val;
    } key_evt_t;

    // Only an exact single mapped bit is a key; anything else decodes to K_NONE.
    function automatic key_evt_t decode_key(input logic [15:0] oh);
        key_evt_t e;
        e.kind = K_NONE;
        e.val  = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (oh == (16'h1 << DIGIT_BIT[i])) begin
                e.kind = K_DIGIT;
                e.val  = 4'(i);
            end
        end
        if (oh == (16'h1 << KEY_ENTER))     e.kind = K_ENTER;
        if (oh == (16'h1 << KEY_CLEAR))     e.kind = K_CLEAR;
        if (oh == (16'h1 << KEY_CLEAR_ALL)) e.kind = K_CLEAR_ALL;
        if (oh == (16'h1 << KEY_SET))       e.kind = K_SET;
        return e;
    endfunction

endpackage

// File: rtl/keypad_lock_ctrl_buzz_seq.sv
// Buzzer tone sequencer: a request restarts the tone on the same edge it is seen.
// Square wave starting high; the fail tone is silent in its middle third.
module buzz_seq
    import keypad_pkg::*;
#(
    parameter int CLICK_HP  = 50000,
    parameter int CLICK_LEN = 10000000,
    parameter int OK_HP     = 25000,
    parameter int OK_LEN    = 30000000,
    parameter int FAIL_HP   = 100000,
    parameter int FAIL_LEN  = 15000000
) (
    input  logic  clk,
    input  logic  rst_n,
    input  tone_t req_i,
    output logic  buzz_o
);

    localparam int MAX_LEN = (CLICK_LEN > OK_LEN) ? ((CLICK_LEN > FAIL_LEN) ? CLICK_LEN : FAIL_LEN)
                                                  : ((OK_LEN > FAIL_LEN) ? OK_LEN : FAIL_LEN);
    localparam int MAX_HP  = (CLICK_HP > OK_HP) ? ((CLICK_HP > FAIL_HP) ? CLICK_HP : FAIL_HP)
                                                : ((OK_HP > FAIL_HP) ? OK_HP : FAIL_HP);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int HW = $clog2(MAX_HP + 1);
    localparam logic [CW-1:0] FAIL_T1 = CW'(FAIL_LEN / 3);
    localparam logic [CW-1:0] FAIL_T2 = CW'(2 * (FAIL_LEN / 3));

    tone_t          mode_q, mode_d;
    logic [CW-1:0]  cnt_q, cnt_d, len_m1;
    logic [HW-1:0]  ph_q, ph_d, hp_m1;
    logic           tog_q, tog_d;
    logic           buzz_q, buzz_d;

    always_comb begin
        len_m1 = CW'(CLICK_LEN - 1);
        hp_m1  = HW'(CLICK_HP - 1);
        case (mode_q)
            TONE_OK: begin
                len_m1 = CW'(OK_LEN - 1);
                hp_m1  = HW'(OK_HP - 1);
            end
            TONE_FAIL: begin
                len_m1 = CW'(FAIL_LEN - 1);
                hp_m1  = HW'(FAIL_HP - 1);
            end
            default: ;
        endcase
    end

    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        ph_d   = ph_q;
        tog_d  = tog_q;
        if (req_i != TONE_NONE) begin
            mode_d = req_i;
            cnt_d  = '0;
            ph_d   = '0;
            tog_d  = 1'b1;
        end else if (mode_q != TONE_NONE) begin
            if (cnt_q == len_m1) begin
                mode_d = TONE_NONE;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (ph_q == hp_m1) begin
                    ph_d  = '0;
                    tog_d = ~tog_q;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
        end
        // The square wave keeps its phase through the silent third of the fail tone.
        buzz_d = (mode_d != TONE_NONE) && tog_d &&
                 !((mode_d == TONE_FAIL) && (cnt_d >= FAIL_T1) && (cnt_d < FAIL_T2));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= TONE_NONE;
            cnt_q  <= '0;
            ph_q   <= '0;
            tog_q  <= 1'b0;
            buzz_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            ph_q   <= ph_d;
            tog_q  <= tog_d;
            buzz_q <= buzz_d;
        end
    end

    assign buzz_o = buzz_q;

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad code lock: BCD entry, programmable code, failed-try count and timed lockout.
// All outputs are registered and change one clk after the edge that samples a key.
module keypad_lock_ctrl
    import keypad_pkg::*;
#(
    parameter int                      CODE_LEN     = 3,
    parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE = 12'h246,
    parameter int                      MAX_TRIES    = 4,
    parameter int                      LOCK_SECS    = 60,
    parameter int                      CLK_HZ       = 50000000,
    parameter int                      CLICK_HP     = 50000,
    parameter int                      CLICK_LEN    = 10000000,
    parameter int                      OK_HP        = 25000,
    parameter int                      OK_LEN       = 30000000,
    parameter int                      FAIL_HP      = 100000,
    parameter int                      FAIL_LEN     = 15000000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [15:0]                      onehot,
    output logic [4*CODE_LEN-1:0]            digits,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries,
    output logic                             pass,
    output logic                             locked,
    output logic                             buzzer
);

    localparam int DW  = 4 * CODE_LEN;
    localparam int CNW = $clog2(CODE_LEN + 1);
    localparam int TW  = $clog2(MAX_TRIES + 1);
    localparam int PW  = $clog2(CLK_HZ + 1);
    localparam logic [CNW-1:0] FULL      = CNW'(CODE_LEN);
    localparam logic [TW-1:0]  TRIES_MAX = TW'(MAX_TRIES);
    localparam logic [6:0]     SECS      = 7'(LOCK_SECS);
    localparam logic [PW-1:0]  PRESC_TOP = PW'(CLK_HZ - 1);
    localparam logic [DW-1:0]  ALL_BLANK = {CODE_LEN{BLANK}};
    localparam logic [DW-1:0]  ALL_PASS  = {CODE_LEN{PASS_GLYPH}};

    // Remaining seconds in BCD on the two lowest digits, the rest blank.
    function automatic logic [DW-1:0] lock_disp(input logic [6:0] rem);
        logic [DW-1:0] v;
        v      = ALL_BLANK;
        v[3:0] = 4'(rem % 7'd10);
        for (int i = 1; i < CODE_LEN; i++) begin
            if (i == 1) v[4*i +: 4] = 4'(rem / 7'd10);
        end
        return v;
    endfunction

    state_t          state_q, state_d;
    logic [DW-1:0]   digits_q, digits_d;
    logic [DW-1:0]   code_q, code_d;
    logic [CNW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]   tries_q, tries_d, tries_inc;
    logic [15:0]     prev_q;
    logic [6:0]      rem_q, rem_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            pass_q, pass_d, locked_q, locked_d;
    logic [DW+3:0]   shifted;
    key_evt_t        kev;
    key_kind_t       kind;
    tone_t           tone_req;

    always_comb begin
        state_d   = state_q;
        digits_d  = digits_q;
        code_d    = code_q;
        cnt_d     = cnt_q;
        tries_d   = tries_q;
        rem_d     = rem_q;
        presc_d   = presc_q;
        tone_req  = TONE_NONE;
        kev       = decode_key(onehot);
        kind      = (prev_q == 16'h0) ? kev.kind : K_NONE;
        shifted   = {digits_q, kev.val};
        tries_inc = tries_q + 1'b1;

        case (state_q)
            ENTRY, NEWCODE: begin
                case (kind)
                    K_DIGIT: begin
                        if (cnt_q != FULL) begin
                            digits_d = shifted[DW-1:0];
                            cnt_d    = cnt_q + 1'b1;
                            tone_req = TONE_CLICK;
                        end
                    end
                    K_ENTER: begin
                        if (cnt_q == FULL) begin
                            digits_d = ALL_BLANK;
                            cnt_d    = '0;
                            if (state_q == NEWCODE) begin
                                code_d   = digits_q;
                                state_d  = ENTRY;
                                tone_req = TONE_OK;
                            end else if (digits_q == code_q) begin
                                state_d  = PASS;
                                tries_d  = '0;
                                digits_d = ALL_PASS;
                                tone_req = TONE_OK;
                            end else begin
                                tries_d  = tries_inc;
                                tone_req = TONE_FAIL;
                                if (tries_inc == TRIES_MAX) begin
                                    state_d  = LOCKOUT;
                                    rem_d    = SECS;
                                    presc_d  = '0;
                                    digits_d = lock_disp(SECS);
                                end
                            end
                        end
                    end
                    K_CLEAR: begin
                        digits_d = ALL_BLANK;
                        cnt_d    = '0;
                    end
                    K_CLEAR_ALL: begin
                        digits_d = ALL_BLANK;
                        cnt_d    = '0;
                        tries_d  = '0;
                        state_d  = ENTRY;
                    end
                    default: ;
                endcase
            end
            PASS: begin
                case (kind)
                    K_ENTER, K_CLEAR, K_CLEAR_ALL: begin
                        state_d  = ENTRY;
                        digits_d = ALL_BLANK;
                        cnt_d    = '0;
                        tries_d  = '0;
                    end
                    K_SET: begin
                        state_d  = NEWCODE;
                        digits_d = ALL_BLANK;
                        cnt_d    = '0;
                    end
                    default: ;
                endcase
            end
            LOCKOUT: begin
                if (presc_q == PRESC_TOP) begin
                    presc_d = '0;
                    rem_d   = rem_q - 7'd1;
                    if (rem_q == 7'd1) begin
                        state_d  = ENTRY;
                        tries_d  = '0;
                        digits_d = ALL_BLANK;
                        cnt_d    = '0;
                    end else begin
                        digits_d = lock_disp(rem_q - 7'd1);
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: ;
        endcase

        pass_d   = (state_d == PASS) || (state_d == NEWCODE);
        locked_d = (state_d == LOCKOUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ENTRY;
            digits_q <= ALL_BLANK;
            code_q   <= DEFAULT_CODE;
            cnt_q    <= '0;
            tries_q  <= '0;
            prev_q   <= 16'h0;
            rem_q    <= 7'd0;
            presc_q  <= '0;
            pass_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
            tries_q  <= tries_d;
            prev_q   <= onehot;
            rem_q    <= rem_d;
            presc_q  <= presc_d;
            pass_q   <= pass_d;
            locked_q <= locked_d;
        end
    end

    buzz_seq #(
        .CLICK_HP (CLICK_HP),
        .CLICK_LEN(CLICK_LEN),
        .OK_HP    (OK_HP),
        .OK_LEN   (OK_LEN),
        .FAIL_HP  (FAIL_HP),
        .FAIL_LEN (FAIL_LEN)
    ) u_buzz (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (tone_req),
        .buzz_o(buzzer)
    );

    assign digits = digits_q;
    assign tries  = tries_q;
    assign pass   = pass_q;
    assign locked = locked_q;

endmodule
